// File: rtl/rx_frame_checker_pkg.sv
// Shared constants and types for the UART frame checker.
// Optional CRC-8 check byte selected by RX_FRAME_CHECKER_CRC8_EN.
package rx_frame_checker_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam int         CNT_W             = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_EMIT
    } state_t;

    // MSB-first CRC-8 step over one whole byte
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_frame_checker_accum.sv
// Running check-byte accumulator: XOR by default, CRC-8 when
// RX_FRAME_CHECKER_CRC8_EN is defined.
module frame_chk_accum
    import rx_frame_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data_byte,
    output logic [7:0] chk
);

    logic [7:0] chk_q;
    logic [7:0] chk_d;

    always_comb begin
        chk_d = chk_q;
        if (clear) begin
            chk_d = 8'h00;
        end else if (enable) begin
`ifdef RX_FRAME_CHECKER_CRC8_EN
            chk_d = crc8_update(chk_q, data_byte);
`else
            chk_d = chk_q ^ data_byte;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 8'h00;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk = chk_q;

endmodule

// File: rtl/rx_frame_checker.sv
// Frame collector/verifier: SYNC ADDR LEN payload CHK in, verified ADDR LEN payload out.
// Define RX_FRAME_CHECKER_CRC8_EN to switch the check byte from XOR to CRC-8.
module rx_frame_checker
    import rx_frame_checker_pkg::*;
#(
    parameter int         MAX_LEN        = 32,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad,
    output logic             err_flag
);

    localparam int         BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       emit_idx_q, emit_idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] ok_q, ok_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             err_q, err_d;
    logic [7:0]       pay_q [MAX_LEN];

    logic       accept;
    logic       active;
    logic       expire;
    logic       pay_we;
    logic       acc_clear;
    logic       acc_en;
    logic [7:0] acc_chk;

    frame_chk_accum u_accum (
        .clk       (clk),
        .rst       (rst),
        .clear     (acc_clear),
        .enable    (acc_en),
        .data_byte (in_data),
        .chk       (acc_chk)
    );

    assign in_ready  = !rst && (state_q != ST_EMIT);
    assign out_valid = (state_q == ST_EMIT);
    assign out_last  = (state_q == ST_EMIT) && (emit_idx_q == len_q + 8'd1);
    assign accept    = in_valid && in_ready;
    assign active    = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign expire    = active && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        out_data = 8'h00;
        if (state_q == ST_EMIT) begin
            if (emit_idx_q == 8'd0) begin
                out_data = addr_q;
            end else if (emit_idx_q == 8'd1) begin
                out_data = len_q;
            end else begin
                out_data = pay_q[BUF_AW'(emit_idx_q - 8'd2)];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        emit_idx_d = emit_idx_q;
        ok_d       = ok_q;
        bad_d      = bad_q;
        err_d      = 1'b0;
        pay_we     = 1'b0;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        gap_d      = (active && !accept) ? gap_q + GAP_W'(1) : '0;

        // Expiry wins over a byte arriving in the same cycle
        if (expire) begin
            bad_d   = (bad_q != CNT_MAX) ? bad_q + CNT_W'(1) : bad_q;
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    acc_clear = 1'b1;
                    if (accept && in_data == SYNC_BYTE) state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    if (accept) begin
                        addr_d  = in_data;
                        acc_en  = 1'b1;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        len_d  = in_data;
                        acc_en = 1'b1;
                        idx_d  = 8'd0;
                        if (in_data == 8'd0) begin
                            state_d = ST_CHK;
                        end else if (in_data > MAX_LEN_B) begin
                            bad_d   = (bad_q != CNT_MAX) ? bad_q + CNT_W'(1) : bad_q;
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        pay_we = 1'b1;
                        acc_en = 1'b1;
                        idx_d  = idx_q + 8'd1;
                        if (idx_q + 8'd1 == len_q) state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        if (in_data == acc_chk) begin
                            ok_d       = (ok_q != CNT_MAX) ? ok_q + CNT_W'(1) : ok_q;
                            emit_idx_d = 8'd0;
                            state_d    = ST_EMIT;
                        end else begin
                            bad_d   = (bad_q != CNT_MAX) ? bad_q + CNT_W'(1) : bad_q;
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (out_last) state_d = ST_IDLE;
                        else          emit_idx_d = emit_idx_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= 8'h00;
            len_q      <= 8'h00;
            idx_q      <= 8'h00;
            emit_idx_q <= 8'h00;
            gap_q      <= '0;
            ok_q       <= '0;
            bad_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            emit_idx_q <= emit_idx_d;
            gap_q      <= gap_d;
            ok_q       <= ok_d;
            bad_q      <= bad_d;
            err_q      <= err_d;
        end
    end

    // Payload storage holds data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (pay_we) pay_q[BUF_AW'(idx_q)] <= in_data;
    end

    assign frames_ok  = ok_q;
    assign frames_bad = bad_q;
    assign err_flag   = err_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed self-checking bench for rx_frame_checker (XOR or CRC-8 build).
module tb_rx_frame_checker;

    typedef logic [7:0] q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;
    logic        err_flag;

    int   checks = 0;
    int   failures = 0;
    int   rd_ptr = 0;
    int   err_count = 0;
    int   rdy_viol = 0;
    int   stab_viol = 0;
    int   stall_seen = 0;
    logic bp_mode = 1'b0;
    logic was_stall = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] cap_data[$];
    logic       cap_last[$];

    rx_frame_checker #(.MAX_LEN(32), .TIMEOUT_CYCLES(10), .SYNC_BYTE(8'hAA)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frames_ok  (frames_ok),
        .frames_bad (frames_bad),
        .err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    // Output ready toggles every cycle in backpressure mode
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ~out_ready : 1'b1;
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_last.push_back(out_last);
        end
        if (err_flag) err_count++;
        if (out_valid && in_ready) rdy_viol++;
        if (was_stall && (!out_valid || out_data !== stall_data)) stab_viol++;
        if (out_valid && !out_ready) stall_seen++;
        was_stall  = out_valid && !out_ready;
        stall_data = out_data;
    end

    function automatic logic [7:0] model_chk(input q_t b);
        logic [7:0] c = 8'h00;
        foreach (b[i]) begin
`ifdef RX_FRAME_CHECKER_CRC8_EN
            c = c ^ b[i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
`else
            c = c ^ b[i];
`endif
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input q_t body, input logic corrupt);
        applyStimulus(8'hAA);
        foreach (body[i]) applyStimulus(body[i]);
        applyStimulus(model_chk(body) ^ {7'b0, corrupt});
    endtask

    task automatic check_frame(input string tag, input q_t exp);
        int n = 0;
        logic [7:0] d;
        logic       l;
        while ((cap_data.size() - rd_ptr) < exp.size() && n < 400) begin
            idle(1);
            n++;
        end
        idle(2);
        checkOutput({tag, "_count"}, 32'(cap_data.size() - rd_ptr), 32'(exp.size()));
        foreach (exp[i]) begin
            d = (rd_ptr + i < cap_data.size()) ? cap_data[rd_ptr + i] : 8'hxx;
            l = (rd_ptr + i < cap_last.size()) ? cap_last[rd_ptr + i] : 1'bx;
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(d), 32'(exp[i]));
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(l), 32'(i == exp.size() - 1));
        end
        rd_ptr = cap_data.size();
    endtask

    task automatic check_counts(input string tag, input int ok, input int bad, input int errs);
        checkOutput({tag, "_ok"}, 32'(frames_ok), 32'(ok));
        checkOutput({tag, "_bad"}, 32'(frames_bad), 32'(bad));
        checkOutput({tag, "_err"}, 32'(err_count), 32'(errs));
    endtask

    initial begin
        q_t fa;
        q_t fz;
        q_t fl;
        q_t fb;
        q_t fc;
        q_t fr;
        fa = '{8'h05, 8'h02, 8'h11, 8'h22};
        fz = '{8'h07, 8'h00};
        fb = '{8'h09, 8'h03, 8'hAA, 8'hB2, 8'hC3};
        fc = '{8'h01, 8'h00};
        fr = '{8'h02, 8'h00};
        fl.push_back(8'h01);
        fl.push_back(8'd32);
        for (int i = 0; i < 32; i++) fl.push_back(8'(i * 7 + 3));

        idle(3);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_ok", 32'(frames_ok), 32'd0);
        checkOutput("rst_bad", 32'(frames_bad), 32'd0);
        checkOutput("rst_err", 32'(err_flag), 32'd0);
        rst = 1'b0;
        idle(1);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] good frame");
        send_frame(fa, 1'b0);
        check_frame("good", fa);
        check_counts("good", 1, 0, 0);

        $display("[TB] corrupt check byte then good frame");
        send_frame(fa, 1'b1);
        idle(4);
        checkOutput("corrupt_no_out", 32'(cap_data.size() - rd_ptr), 32'd0);
        check_counts("corrupt", 1, 1, 1);
        send_frame(fa, 1'b0);
        check_frame("recover", fa);
        check_counts("recover", 2, 1, 1);

        $display("[TB] oversize length");
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h21);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        idle(4);
        checkOutput("oversize_no_out", 32'(cap_data.size() - rd_ptr), 32'd0);
        check_counts("oversize", 2, 2, 2);

        $display("[TB] timeout then zero-length frame");
        applyStimulus(8'hAA);
        applyStimulus(8'h05);
        idle(12);
        check_counts("timeout", 2, 3, 3);
        send_frame(fz, 1'b0);
        check_frame("len0", fz);
        check_counts("len0", 3, 3, 3);

        $display("[TB] maximum length frame");
        send_frame(fl, 1'b0);
        check_frame("maxlen", fl);
        check_counts("maxlen", 4, 3, 3);

        $display("[TB] backpressure with sync value in payload");
        bp_mode = 1'b1;
        send_frame(fb, 1'b0);
        check_frame("bp", fb);
        bp_mode = 1'b0;
        idle(2);
        checkOutput("bp_stalled", 32'(stall_seen > 0), 32'd1);
        checkOutput("bp_stable", 32'(stab_viol), 32'd0);
        checkOutput("emit_in_ready_low", 32'(rdy_viol), 32'd0);
        check_counts("bp", 5, 3, 3);

        $display("[TB] crc vector pair");
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h15);
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        check_frame("crcpair", fc);
        check_counts("crcpair", 6, 4, 4);

        $display("[TB] reset mid payload");
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h04);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        rst = 1'b1;
        idle(1);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_last", 32'(out_last), 32'd0);
        checkOutput("midrst_out_data", 32'(out_data), 32'd0);
        checkOutput("midrst_ok", 32'(frames_ok), 32'd0);
        checkOutput("midrst_bad", 32'(frames_bad), 32'd0);
        checkOutput("midrst_err", 32'(err_flag), 32'd0);
        rst = 1'b0;
        idle(1);
        checkOutput("midrst_ready_after", 32'(in_ready), 32'd1);
        send_frame(fr, 1'b0);
        check_frame("after_rst", fr);
        checkOutput("after_rst_ok", 32'(frames_ok), 32'd1);
        checkOutput("after_rst_bad", 32'(frames_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
